// File: rtl/wave_capture_if.sv
// Bundle between the audio sample source / waveform RAM / display and wave_capture.
//   new_sample_ready  : one-cycle strobe, new_sample_in valid
//   new_sample_in     : signed 16-bit sample
//   wave_display_idle : display outside drawing region, bank swap safe
//   write_address     : {bank, index} RAM write address
//   write_enable      : one-cycle RAM write strobe
//   write_sample      : unsigned 8-bit sample for the RAM
//   read_index        : bank the display reads
//   capture_state     : 0 ARMED, 1 ACTIVE, 2 WAIT
//   forced_trigger    : current/most recent capture started by timeout
interface wave_capture_if;
   logic               new_sample_ready;
   logic signed [15:0] new_sample_in;
   logic               wave_display_idle;
   logic [8:0]         write_address;
   logic               write_enable;
   logic [7:0]         write_sample;
   logic               read_index;
   logic [1:0]         capture_state;
   logic               forced_trigger;

   modport master (
      output new_sample_ready, new_sample_in, wave_display_idle,
      input  write_address, write_enable, write_sample, read_index, capture_state,
             forced_trigger
   );

   modport slave (
      input  new_sample_ready, new_sample_in, wave_display_idle,
      output write_address, write_enable, write_sample, read_index, capture_state,
             forced_trigger
   );
endinterface

// File: rtl/wave_capture.sv
// Double-buffered oscilloscope-style capture of a decimated audio stream.
// Waits for a rising zero crossing (or a timeout), writes 256 samples into the
// bank the display is not reading, then swaps banks when the display is idle.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : wave_capture_if.slave (sample input, RAM write port, status outputs)
module wave_capture #(
   parameter int unsigned DECIM       = 1,
   parameter int unsigned ARM_TIMEOUT = 1024
) (
   input logic           clk,
   input logic           reset,
   wave_capture_if.slave bus
);

   typedef enum logic [1:0] {
      StArmed  = 2'd0,
      StActive = 2'd1,
      StWait   = 2'd2
   } state_e;

   localparam logic [7:0]  DecMax = 8'(DECIM - 1);
   localparam logic [15:0] ToMax  = 16'(ARM_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [7:0]  dec_cnt_q, dec_cnt_d;
   logic        prev_neg_q, prev_neg_d;
   logic [15:0] to_cnt_q, to_cnt_d;
   logic [7:0]  idx_q, idx_d;
   logic        read_index_q, read_index_d;
   logic        forced_q, forced_d;
   logic        we_q, we_d;
   logic [8:0]  wr_addr_q, wr_addr_d;
   logic [7:0]  wr_sample_q, wr_sample_d;

   logic       accept;
   logic       trigger;
   logic       timeout_hit;
   logic [7:0] sample_byte;

   assign accept      = bus.new_sample_ready && (dec_cnt_q == 8'd0);
   assign trigger     = accept && prev_neg_q && !bus.new_sample_in[15];
   assign timeout_hit = accept && !trigger && (to_cnt_q == ToMax);
   // Upper byte with the sign bit flipped: signed to offset-binary.
   assign sample_byte = {~bus.new_sample_in[15], bus.new_sample_in[14:8]};

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= StArmed;
         dec_cnt_q    <= 8'd0;
         prev_neg_q   <= 1'b0;
         to_cnt_q     <= 16'd0;
         idx_q        <= 8'd0;
         read_index_q <= 1'b0;
         forced_q     <= 1'b0;
         we_q         <= 1'b0;
         wr_addr_q    <= 9'd0;
         wr_sample_q  <= 8'd0;
      end else begin
         state_q      <= state_d;
         dec_cnt_q    <= dec_cnt_d;
         prev_neg_q   <= prev_neg_d;
         to_cnt_q     <= to_cnt_d;
         idx_q        <= idx_d;
         read_index_q <= read_index_d;
         forced_q     <= forced_d;
         we_q         <= we_d;
         wr_addr_q    <= wr_addr_d;
         wr_sample_q  <= wr_sample_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StArmed:  if (trigger || timeout_hit) state_d = StActive;
         StActive: if (accept && idx_q == 8'hFF) state_d = StWait;
         StWait:   if (bus.wave_display_idle) state_d = StArmed;
         default:  state_d = StArmed;
      endcase
   end

   // Datapath and registered outputs
   always_comb begin
      dec_cnt_d    = dec_cnt_q;
      prev_neg_d   = prev_neg_q;
      to_cnt_d     = to_cnt_q;
      idx_d        = idx_q;
      read_index_d = read_index_q;
      forced_d     = forced_q;
      we_d         = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_sample_d  = wr_sample_q;

      // Decimation and sign tracking run in every state.
      if (bus.new_sample_ready) begin
         dec_cnt_d = (dec_cnt_q == DecMax) ? 8'd0 : dec_cnt_q + 8'd1;
      end
      if (accept) prev_neg_d = bus.new_sample_in[15];

      case (state_q)
         StArmed: begin
            if (trigger || timeout_hit) begin
               forced_d    = timeout_hit;
               we_d        = 1'b1;
               wr_addr_d   = {~read_index_q, 8'h00};
               wr_sample_d = sample_byte;
               idx_d       = 8'd1;
               to_cnt_d    = 16'd0;
            end else if (accept) begin
               to_cnt_d = to_cnt_q + 16'd1;
            end
         end
         StActive: begin
            if (accept) begin
               we_d        = 1'b1;
               wr_addr_d   = {~read_index_q, idx_q};
               wr_sample_d = sample_byte;
               // Hold at 255; the index restarts only when a new capture begins.
               if (idx_q != 8'hFF) idx_d = idx_q + 8'd1;
            end
         end
         StWait: begin
            if (bus.wave_display_idle) begin
               read_index_d = ~read_index_q;
               to_cnt_d     = 16'd0;
            end
         end
         default: ;
      endcase
   end

   // Outputs
   always_comb begin
      bus.capture_state  = state_q;
      bus.read_index     = read_index_q;
      bus.forced_trigger = forced_q;
      bus.write_enable   = we_q;
      bus.write_address  = wr_addr_q;
      bus.write_sample   = wr_sample_q;
   end

endmodule
